// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit drain path.
package uart_pkg;

  // Payload width; kept equal to the FIFO word width feeding this block.
  localparam int DATA_WIDTH   = 8;
  // 100 MHz system clock / 115200 baud.
  localparam int CLKS_PER_BIT = 868;
  localparam int STOP_BITS    = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate divider: free-running 0..CLKS_PER_BIT-1 counter with a
// registered tick that is high while the count sits at its last value.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count: clear restarts a bit period, otherwise count and wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_drain_checker.sv
// Protocol checks for the UART transmit drain FSM.
module uart_tx_drain_checker
  import uart_pkg::*;
(
  input logic           clk,
  input logic           rst,
  input logic           fifo_empty,
  input logic           fifo_rd_en,
  input logic           tx,
  input logic           busy,
  input logic           frame_end,
  input uart_tx_state_t state_q,
  input uart_tx_state_t state_d
);

  a_pop_not_empty: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |-> !fifo_empty)
    else $warning("uart_tx_drain_checker: pop while FIFO empty");

  a_pop_to_start: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |-> (state_d == START))
    else $warning("uart_tx_drain_checker: pop not followed by START");

  a_idle_tx_high: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> tx)
    else $warning("uart_tx_drain_checker: line low while idle");

  a_one_pop_per_frame: assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |-> ((state_q == IDLE) || frame_end))
    else $warning("uart_tx_drain_checker: pop inside a frame");

  a_busy_not_idle: assert property (@(posedge clk) disable iff (rst)
    busy |-> (state_q != IDLE))
    else $warning("uart_tx_drain_checker: busy while idle");

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter draining a show-ahead FIFO: pops a word when idle (or on
// the final stop-bit cycle for gapless back-to-back frames) and shifts it out
// LSB-first with optional even parity and one or two stop bits.
module uart_tx_drain #(
  parameter int DATA_WIDTH   = uart_pkg::DATA_WIDTH,
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = uart_pkg::STOP_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy
);

  import uart_pkg::*;

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $fatal(1, "uart_tx_drain: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $fatal(1, "uart_tx_drain: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH == 0) begin : g_bad_dw
    $fatal(1, "uart_tx_drain: DATA_WIDTH must be non-zero");
  end

  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  function automatic logic even_parity_bit(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  uart_tx_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tick_s;
  logic                  frame_end_s;
  logic                  pop_s;
  logic                  clear_s;

  // Last cycle of the final stop bit, and the FIFO pop decision.
  always_comb begin
    frame_end_s = (state_q == STOP) && tick_s && (bit_cnt_q == LAST_STOP);
    pop_s = !rst && enable && !fifo_empty && ((state_q == IDLE) || frame_end_s);
    clear_s = (state_q == IDLE) || pop_s;
  end

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear_s),
    .tick (tick_s)
  );

  // Frame sequencing: next state, shift register, parity and bit counter.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          shift_d   = fifo_rd_data;
          parity_d  = even_parity_bit(fifo_rd_data);
          bit_cnt_d = '0;
          state_d   = START;
        end else begin
          state_d   = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          state_d   = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end else begin
          state_d   = PARITY;
        end
      end
      STOP: begin
        if (frame_end_s) begin
          bit_cnt_d = '0;
          if (pop_s) begin
            shift_d  = fifo_rd_data;
            parity_d = even_parity_bit(fifo_rd_data);
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end else if (tick_s) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level and busy flag follow the next state so tx moves on the pop edge.
  always_comb begin
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign fifo_rd_en = pop_s;
  assign tx         = tx_q;
  assign busy       = busy_q;

  uart_tx_drain_checker u_chk (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(pop_s),
    .tx        (tx_q),
    .busy      (busy_q),
    .frame_end (frame_end_s),
    .state_q   (state_q),
    .state_d   (state_d)
  );

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench: two DUTs (8N1 and 8E2, CLKS_PER_BIT=4) fed from
// queue-based FIFO models, checked cycle by cycle against a frame-level model.
module tb_uart_tx_drain;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enable;
  logic [7:0] rd_data_s [2];
  logic       empty_s   [2];
  logic       rd_en_s   [2];
  logic       tx_s      [2];
  logic       busy_s    [2];

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rd_data(rd_data_s[0]),
    .fifo_empty(empty_s[0]), .fifo_rd_en(rd_en_s[0]), .tx(tx_s[0]), .busy(busy_s[0]));

  uart_tx_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rd_data(rd_data_s[1]),
    .fifo_empty(empty_s[1]), .fifo_rd_en(rd_en_s[1]), .tx(tx_s[1]), .busy(busy_s[1]));

  // Model state: FIFO contents and the expected line level of every pending cycle.
  logic [7:0] fq  [2][$];
  bit         exq [2][$];
  logic [2:0] obs  [2];   // {tx, busy, rd_en} seen this cycle
  logic [2:0] expv [2];   // {tx, busy, rd_en} predicted this cycle
  int nvec;
  int nerr;

  function automatic void drive();
    for (int d = 0; d < 2; d++) begin
      empty_s[d]   = (fq[d].size() == 0);
      rd_data_s[d] = (fq[d].size() == 0) ? 8'h00 : fq[d][0];
    end
  endfunction

  // Expand a word into its per-cycle line levels for DUT d.
  function automatic void push_frame(int d, logic [7:0] w);
    int nstop;
    nstop = (d == 0) ? 1 : 2;
    for (int k = 0; k < CPB; k++) exq[d].push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < CPB; k++) exq[d].push_back(w[i]);
    if (d == 1)
      for (int k = 0; k < CPB; k++) exq[d].push_back(^w);
    for (int k = 0; k < nstop * CPB; k++) exq[d].push_back(1'b1);
  endfunction

  // One clock: predict and sample mid-cycle, then advance the model at the edge.
  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      expv[d][2] = (exq[d].size() > 0) ? exq[d][0] : 1'b1;
      expv[d][1] = (exq[d].size() > 0);
      expv[d][0] = !rst && enable && (fq[d].size() > 0) && (exq[d].size() <= 1);
      obs[d]     = {tx_s[d], busy_s[d], rd_en_s[d]};
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (exq[d].size() > 0) void'(exq[d].pop_front());
      if (rst) exq[d].delete();
      if (expv[d][0]) push_frame(d, fq[d].pop_front());
    end
    #1;
    drive();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    fq[0].push_back(8'h3C);
    fq[1].push_back(8'hC3);
    drive();
    repeat (3) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== 3'b100 || obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL reset dut%0d t=%0t {tx,busy,rd_en} got %b want 100", d, $time, obs[d]);
        end
      end
    end
    fq[0].delete();
    fq[1].delete();
    drive();
    rst = 1'b0;
    repeat (2) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL reset_idle dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
    end
  endtask

  task automatic test_single();
    int pops, busy_n;
    logic [9:0] seq;
    pops = 0; busy_n = 0; seq = '0;
    enable = 1'b1;
    fq[0].push_back(8'hA5);
    drive();
    repeat (46) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL single dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
      if (obs[0][1] && (busy_n % CPB == 1) && (busy_n < 40)) seq[busy_n / CPB] = obs[0][2];
      pops += int'(obs[0][0]);
      busy_n += int'(obs[0][1]);
    end
    nvec++;
    if (pops != 1) begin nerr++; $display("FAIL single_pops got %0d want 1", pops); end
    nvec++;
    if (busy_n != 40) begin nerr++; $display("FAIL single_busy got %0d want 40", busy_n); end
    nvec++;
    if (seq !== 10'b1101001010) begin
      nerr++;
      $display("FAIL single_bits got %b want 1101001010", seq);
    end
  endtask

  task automatic test_back_to_back();
    int pops, run, mx;
    pops = 0; run = 0; mx = 0;
    fq[0].push_back(8'h01);
    fq[0].push_back(8'hFF);
    drive();
    repeat (86) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL b2b dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
      pops += int'(obs[0][0]);
      run = obs[0][1] ? run + 1 : 0;
      if (run > mx) mx = run;
    end
    nvec++;
    if (pops != 2) begin nerr++; $display("FAIL b2b_pops got %0d want 2", pops); end
    nvec++;
    if (mx != 80) begin nerr++; $display("FAIL b2b_busy_run got %0d want 80", mx); end
  endtask

  task automatic test_parity();
    int pops, busy_n;
    logic par;
    pops = 0; busy_n = 0; par = 1'bx;
    fq[1].push_back(8'h07);
    drive();
    repeat (52) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL parity dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
      if (obs[1][1] && busy_n == 37) par = obs[1][2];
      pops += int'(obs[1][0]);
      busy_n += int'(obs[1][1]);
    end
    nvec++;
    if (pops != 1) begin nerr++; $display("FAIL parity_pops got %0d want 1", pops); end
    nvec++;
    if (busy_n != 48) begin nerr++; $display("FAIL parity_frame got %0d want 48", busy_n); end
    nvec++;
    if (par !== 1'b1) begin nerr++; $display("FAIL parity_bit got %b want 1", par); end
  endtask

  task automatic test_reset_midframe();
    int pops, post;
    pops = 0; post = 0;
    fq[0].push_back(8'h00);
    fq[0].push_back(8'h5A);
    drive();
    repeat (11) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL rst_mid dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
      pops += int'(obs[0][0]);
    end
    rst = 1'b1;
    for (int c = 0; c < 46; c++) begin
      cyc();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL rst_mid_after dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
      if (c == 1) begin
        nvec++;
        if (obs[0][2:1] !== 2'b10) begin
          nerr++;
          $display("FAIL rst_mid_line got tx,busy=%b want 10", obs[0][2:1]);
        end
      end
      pops += int'(obs[0][0]);
      post += int'(obs[0][0]);
    end
    nvec++;
    if (post != 1 || pops != 2) begin
      nerr++;
      $display("FAIL rst_mid_pops got post=%0d total=%0d want 1 and 2", post, pops);
    end
  endtask

  task automatic test_enable_drop();
    int pops;
    pops = 0;
    fq[0].push_back(8'h11);
    fq[0].push_back(8'h22);
    drive();
    for (int c = 0; c < 50; c++) begin
      if (c == 10) enable = 1'b0;
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL en_drop dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
      pops += int'(obs[0][0]);
    end
    nvec++;
    if (pops != 1) begin nerr++; $display("FAIL en_drop_pops got %0d want 1", pops); end
    enable = 1'b1;
    for (int c = 0; c < 43; c++) begin
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL en_resume dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
      if (c == 0) begin
        nvec++;
        if (obs[0][0] !== 1'b1) begin
          nerr++;
          $display("FAIL en_resume_pop got %b want 1", obs[0][0]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2200; c++) begin
      if (c < 1900) begin
        if ($urandom_range(0, 59) == 0) fq[$urandom_range(0, 1)].push_back(8'($urandom));
        if ($urandom_range(0, 39) == 0) enable = ~enable;
        rst = ($urandom_range(0, 399) == 0);
      end else begin
        rst = 1'b0;
        enable = 1'b1;
      end
      drive();
      cyc();
      for (int d = 0; d < 2; d++) begin
        nvec++;
        if (obs[d] !== expv[d]) begin
          nerr++;
          $display("FAIL random dut%0d t=%0t got %b want %b", d, $time, obs[d], expv[d]);
        end
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    enable = 1'b0;
    drive();
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
UART transmit serializer directly downstream of the synchronous FIFO. It pops one word from the FIFO's show-ahead read port whenever it is idle and the FIFO is non-empty, then shifts that word out LSB-first as an 8N1/8E1/8N2-style asynchronous serial frame. It is the CPU's debug/console TX path: the core writes bytes into the FIFO, and this block drains them at the baud rate.

Parameters:
DATA_WIDTH, 8, payload bits per frame; matches the FIFO word width (fifo_pkg::DATA_WIDTH).
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  permits starting a new frame; a frame already in progress always completes
fifo_rd_data  in  DATA_WIDTH  FIFO head word; combinational, valid whenever fifo_empty=0
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  pop strobe, combinational, one cycle per accepted word
tx  out  1  serial line, registered, idle high
busy  out  1  registered; 1 from the cycle after a pop until the end of the last stop bit

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, tx=1, busy=0, baud and bit counters=0, shift register=0. fifo_rd_en=0 whenever rst=1.
- States: IDLE, START, DATA, PARITY (only if PARITY_EN), STOP.
- Pop condition: pop = !rst && enable && !fifo_empty && (state==IDLE || last cycle of STOP). fifo_rd_en=pop. A pop is never issued while fifo_empty=1.
- On a pop edge: shift_reg <= fifo_rd_data, parity <= ^fifo_rd_data, baud counter <= 0, state <= START.
- Line timing:
  - tx is registered from the next state, so it falls on the edge that accepts the pop. Latency is one cycle from the cycle fifo_rd_en=1 to tx=0.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right at each bit end; after DATA_WIDTH bits, go to PARITY or STOP.
  - PARITY: tx=parity (even: data plus parity bit has an even number of ones) for CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of STOP: go to START if a pop occurs (back-to-back frames with no idle gap), else go to IDLE.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles exactly.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps; a bit boundary occurs at CLKS_PER_BIT-1. Bit counter: width $clog2(DATA_WIDTH)+1.
- busy=1 in START/DATA/PARITY/STOP and 0 in IDLE. During back-to-back frames busy stays 1 with no gap.
- enable dropped mid-frame: the current frame finishes normally, and no new pop occurs until enable=1.
- fifo_empty rising mid-frame: has no effect on the current frame.
- Reset mid-frame: tx=1 and state=IDLE on the next edge. The word in flight is discarded and the FIFO is not re-popped.
- Compile-time $fatal checks: CLKS_PER_BIT<2, STOP_BITS not in {1,2}, DATA_WIDTH==0.
- Assertions:
  - fifo_rd_en implies !fifo_empty.
  - fifo_rd_en implies the next state is START.
  - tx==1 whenever state==IDLE.
  - At most one pop per frame.
  - busy implies state!=IDLE.

Decomposition:
- Package uart_pkg holds:
  - the typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - default constants CLKS_PER_BIT and STOP_BITS;
  - DATA_WIDTH re-exported from fifo_pkg.
- One sub-module, uart_baud_gen: parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick (one cycle at count CLKS_PER_BIT-1). The top level holds the FSM, shift register, parity and bit counter.

Test Plan:
1. Reset with CLKS_PER_BIT=4; hold rst=1 for 3 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0 throughout.
2. Push 0xA5, enable=1, PARITY_EN=0, STOP_BITS=1 -> exactly one fifo_rd_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; frame = 40 cycles; busy=1 for exactly 40 cycles.
3. Push 0x01, 0xFF back-to-back -> second fifo_rd_en falls on the last stop cycle of frame 1; tx has no idle gap; 80 consecutive busy cycles.
4. PARITY_EN=1, STOP_BITS=2; send 0x07 -> parity bit=1; frame = 12*4 = 48 cycles; tx=1 for the final 8 cycles.
5. Assert rst at cycle 10 of a 0x00 frame -> tx=1 on the next edge, state=IDLE, no extra pop; after rst falls, the next queued word sends a complete frame.
6. Set enable=0 during frame 1 with 2 words queued -> frame 1 completes, fifo_rd_en stays 0 and tx stays 1; setting enable=1 pops word 2 in the same cycle.
